// File: rtl/conv_pkg.sv
// Shared definitions for the CONV pixel pipeline: data widths and accumulator FSM encodings.
package conv_pkg;

  localparam int CONV_PIX_W  = 8;
  localparam int CONV_PROD_W = 16;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'b00,
    ST_ROUND = 2'b01,
    ST_OUT   = 2'b10
  } conv_state_e;

endpackage

// File: rtl/conv_round_sat.sv
// Combinational round-half-up, arithmetic right shift and signed saturation of an accumulator sum.
module conv_round_sat #(
  parameter int ACC_W = 24,
  parameter int SHIFT = 7,
  parameter int OUT_W = 8
) (
  input  logic [ACC_W-1:0] acc,
  output logic [OUT_W-1:0] data,
  output logic             sat
);

  localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND =
    (SHIFT > 0) ? ((ACC_W+1)'(1) << RND_POS) : '0;
  localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  // Bitwise inverse of 2^(n-1)-1 is exactly -2^(n-1).
  localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

  // One guard bit so adding the rounding constant can never wrap.
  logic signed [ACC_W:0] sum_w;
  logic signed [ACC_W:0] shifted;

  always_comb begin
    sum_w   = $signed({acc[ACC_W-1], acc}) + RND;
    shifted = sum_w >>> SHIFT;
    data    = shifted[OUT_W-1:0];
    sat     = 1'b0;
    if (shifted > MAX_V) begin
      data = MAX_V[OUT_W-1:0];
      sat  = 1'b1;
    end else if (shifted < MIN_V) begin
      data = MIN_V[OUT_W-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/conv_accum.sv
// Accumulates TAPS signed products per pixel, then rounds/shifts/saturates to one signed pixel.
//   state    | meaning
//   ST_ACCUM | accepting products, counting taps
//   ST_ROUND | one cycle: register rounded, saturated result
//   ST_OUT   | result held until consumer handshake
module conv_accum
  import conv_pkg::*;
#(
  parameter int TAPS  = 9,
  parameter int ACC_W = 24,
  parameter int SHIFT = 7,
  parameter int OUT_W = CONV_PIX_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [CONV_PROD_W-1:0] in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_sat,
  input  logic                   out_ready
);

  localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);

  generate
    if (TAPS < 1) begin : g_bad_taps
      $error("conv_accum: TAPS must be >= 1");
    end
    if (ACC_W < CONV_PROD_W + $clog2(TAPS)) begin : g_bad_acc_w
      $error("conv_accum: ACC_W too narrow for TAPS products");
    end
    if (SHIFT < 0 || SHIFT > ACC_W - 2) begin : g_bad_shift
      $error("conv_accum: SHIFT out of range");
    end
  endgenerate

  conv_state_e state, state_nxt;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] in_ext;
  logic [OUT_W-1:0] rs_data;
  logic             rs_sat;
  logic             accept;
  logic             out_hs;

  assign in_ext = {{(ACC_W-CONV_PROD_W){in_data[CONV_PROD_W-1]}}, in_data};

  // Gated by the reset input so the block never advertises ready while held in reset.
  assign in_ready = reset && (state == ST_ACCUM);
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  conv_round_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .acc  (acc),
    .data (rs_data),
    .sat  (rs_sat)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACCUM: if (accept && cnt == CNT_LAST) state_nxt = ST_ROUND;
      ST_ROUND: state_nxt = ST_OUT;
      ST_OUT:   if (out_hs) state_nxt = ST_ACCUM;
      default:  state_nxt = ST_ACCUM;
    endcase
    if (flush) state_nxt = ST_ACCUM;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (flush) begin
      // out_data/out_sat deliberately keep the last result.
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (accept) begin
            acc <= acc + in_ext;
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
          end
        end
        ST_ROUND: begin
          out_data  <= rs_data;
          out_sat   <= rs_sat;
          out_valid <= 1'b1;
        end
        ST_OUT: begin
          if (out_hs) begin
            out_valid <= 1'b0;
            acc       <= '0;
          end
        end
        default: begin
          acc <= '0;
          cnt <= '0;
        end
      endcase
    end
  end

endmodule
